// File: rtl/key_pio_debounce.sv
// Debounced key PIO with an Avalon-MM register slave.
// Supports press or both-edge capture and a level interrupt.
module key_pio_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_export,
   input  logic [1:0]          avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic                irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_KEYS-1:0] POL = {NUM_KEYS{ACTIVE_LOW}};

   logic [NUM_KEYS-1:0] meta;
   logic [NUM_KEYS-1:0] sync;
   logic [NUM_KEYS-1:0] stable;
   logic [NUM_KEYS-1:0] done;
   logic [NUM_KEYS-1:0] hit;
   logic [NUM_KEYS-1:0] clr;
   logic [NUM_KEYS-1:0] wdata;
   logic [NUM_KEYS-1:0] mask;
   logic [NUM_KEYS-1:0] cap;
   logic [NUM_KEYS-1:0] sel;
   logic [CW-1:0]       cnt    [NUM_KEYS];
   logic [CW-1:0]       cnt_nx [NUM_KEYS];
   logic [31:0]         rd_mux;

   assign wdata = avs_writedata[NUM_KEYS-1:0];

   generate
      if (NUM_KEYS < 32) begin : g_unused
         logic unused;
         assign unused = ^avs_writedata[31:NUM_KEYS];
      end
   endgenerate

   // Count consecutive cycles the synchronized level differs from stable.
   always_comb begin
      done = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt_nx[i] = '0;
         if (sync[i] != stable[i]) begin
            if (cnt[i] == LAST) begin
               done[i] = 1'b1;
            end else begin
               cnt_nx[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   assign hit = (done & sync) | (done & ~sync & sel);

   always_comb begin
      clr = '0;
      if (avs_write && avs_address == 2'd2) begin
         clr = wdata;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (avs_address)
         2'd0: rd_mux = 32'(stable);
         2'd1: rd_mux = 32'(mask);
         2'd2: rd_mux = 32'(cap);
         2'd3: rd_mux = 32'(sel);
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         meta         <= '0;
         sync         <= '0;
         stable       <= '0;
         cnt          <= '{default: '0};
         mask         <= '0;
         cap          <= '0;
         sel          <= '0;
         avs_readdata <= '0;
      end else begin
         // Polarity applied at the pin so a reset synchronizer reads released.
         meta   <= key_export ^ POL;
         sync   <= meta;
         stable <= stable ^ done;
         cnt    <= cnt_nx;
         cap    <= (cap & ~clr) | hit;
         if (avs_write && avs_address == 2'd1) begin
            mask <= wdata;
         end
         if (avs_write && avs_address == 2'd3) begin
            sel <= wdata;
         end
         if (avs_read) begin
            avs_readdata <= rd_mux;
         end
      end
   end

   assign irq = |(cap & mask);

endmodule

// File: tb/tb_key_pio_debounce.sv
// Testbench for key_pio_debounce: directed scenarios plus a
// randomized run against a window-based behavioural model.
module tb_key_pio_debounce;

   localparam int NK = 4;
   localparam int DC = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_export;
   logic [1:0]    avs_address;
   logic          avs_read;
   logic          avs_write;
   logic [31:0]   avs_writedata;
   logic [31:0]   avs_readdata;
   logic          irq;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_pio_debounce #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(DC),
      .ACTIVE_LOW(1)
   ) dut (
      .clk_clk(clk),
      .reset_reset(reset),
      .key_export(key_export),
      .avs_address(avs_address),
      .avs_read(avs_read),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata),
      .irq(irq)
   );

   // Reference: a key flips once the last DC synchronized samples all
   // disagree with its stable level; synchronized = pin two edges ago.
   logic [NK-1:0] pin_q [$];
   logic [NK-1:0] win [$];
   logic [NK-1:0] m_stable, m_mask, m_cap, m_sel;
   logic [31:0]   m_rd;

   always @(posedge clk) begin : model
      logic [NK-1:0] s, flip, qual, clr, wd;
      int n;
      if (reset) begin
         pin_q = {};
         pin_q.push_back('0);
         pin_q.push_back('0);
         win = {};
         repeat (DC) win.push_back('0);
         m_stable = '0;
         m_mask   = '0;
         m_cap    = '0;
         m_sel    = '0;
         m_rd     = '0;
      end else begin
         s = pin_q[0];
         void'(pin_q.pop_front());
         pin_q.push_back(~key_export);
         void'(win.pop_front());
         win.push_back(s);
         flip = '0;
         for (int i = 0; i < NK; i++) begin
            n = 0;
            foreach (win[j]) if (win[j][i] != m_stable[i]) n++;
            if (n == DC) flip[i] = 1'b1;
         end
         if (avs_read) begin
            case (avs_address)
               2'd0: m_rd = 32'(m_stable);
               2'd1: m_rd = 32'(m_mask);
               2'd2: m_rd = 32'(m_cap);
               default: m_rd = 32'(m_sel);
            endcase
         end
         wd   = avs_writedata[NK-1:0];
         clr  = (avs_write && avs_address == 2'd2) ? wd : '0;
         qual = flip & (~m_stable | m_sel);
         m_cap = (m_cap & ~clr) | qual;
         if (avs_write && avs_address == 2'd1) m_mask = wd;
         if (avs_write && avs_address == 2'd3) m_sel = wd;
         m_stable = m_stable ^ flip;
      end
   end

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset      = 1'b1;
      key_export = '1;
      repeat (2) @(negedge clk);
      avs_address   = 2'd1;
      avs_writedata = 32'hF;
      avs_write     = 1'b1;
      avs_read      = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
      avs_read  = 1'b0;
      reset     = 1'b0;
      checks++;
      if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_out rd=%h irq=%b exp rd=0 irq=0",
                  avs_readdata, irq);
      end
      for (int a = 0; a < 4; a++) begin
         bus_rd(a[1:0], d);
         checks++;
         if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_reg%0d got=%h exp=0", a, d);
         end
      end
   endtask

   task automatic test_press;
      logic [31:0] d;
      key_export = 4'b1110;
      repeat (9) @(negedge clk);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL press_early got=%h exp=0", d);
      end
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL press_data got=%h exp=1", d);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h1 || irq !== 1'b0) begin
         failures++;
         $display("FAIL press_cap got=%h irq=%b exp=1 irq=0", d, irq);
      end
      bus_wr(2'd2, 32'h1);
      key_export = '1;
      repeat (12) @(negedge clk);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL release_data got=%h exp=0", d);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL release_nocap got=%h exp=0", d);
      end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      key_export = 4'b1101;
      repeat (7) @(negedge clk);
      key_export = '1;
      repeat (14) @(negedge clk);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL glitch7_data got=%h exp=0", d);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL glitch7_cap got=%h exp=0", d);
      end
      key_export = 4'b1101;
      repeat (8) @(negedge clk);
      key_export = '1;
      repeat (3) @(negedge clk);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h2) begin
         failures++;
         $display("FAIL pulse8_data got=%h exp=2", d);
      end
      repeat (12) @(negedge clk);
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h2) begin
         failures++;
         $display("FAIL pulse8_cap got=%h exp=2", d);
      end
      bus_wr(2'd2, 32'hFFFF_FFFF);
   endtask

   task automatic test_irq_edge_sel;
      logic [31:0] d;
      bus_wr(2'd1, 32'h1);
      key_export = 4'b1110;
      repeat (12) @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_set got=%b exp=1", irq);
      end
      bus_wr(2'd2, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_clr got=%b exp=0", irq);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL w1c got=%h exp=0", d);
      end
      key_export = '1;
      repeat (12) @(negedge clk);
      bus_wr(2'd3, 32'h1);
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL sel0_release got=%h irq=%b exp=0", d, irq);
      end
      key_export = 4'b1110;
      repeat (12) @(negedge clk);
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL sel1_press got=%h exp=1", d);
      end
      bus_wr(2'd2, 32'h1);
      key_export = '1;
      repeat (12) @(negedge clk);
      bus_wr(2'd1, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL mask_off_irq got=%b exp=0", irq);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL sel1_release got=%h exp=1", d);
      end
      bus_rd(2'd3, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL sel_readback got=%h exp=1", d);
      end
      bus_wr(2'd2, 32'h1);
   endtask

   task automatic test_set_wins;
      logic [31:0] d;
      key_export = 4'b1011;
      repeat (9) @(negedge clk);
      bus_wr(2'd2, 32'h4);
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL set_wins got=%h exp=4", d);
      end
      bus_wr(2'd2, 32'h4);
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL clr_after got=%h exp=0", d);
      end
      key_export = '1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      bus_wr(2'd0, 32'hFFFF_FFFF);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL data_ro got=%h exp=0", d);
      end
      avs_address   = 2'd1;
      avs_writedata = 32'hFFFF_FFF5;
      avs_write     = 1'b1;
      avs_read      = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
      avs_read  = 1'b0;
      checks++;
      if (avs_readdata !== 32'h0) begin
         failures++;
         $display("FAIL rd_before_wr got=%h exp=0", avs_readdata);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (avs_readdata !== 32'h0) begin
         failures++;
         $display("FAIL rd_hold got=%h exp=0", avs_readdata);
      end
      bus_rd(2'd1, d);
      checks++;
      if (d !== 32'h5) begin
         failures++;
         $display("FAIL mask_wr got=%h exp=5", d);
      end
      bus_wr(2'd1, 32'h0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      bus_wr(2'd1, 32'hF);
      bus_wr(2'd3, 32'hF);
      key_export = 4'b1110;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (irq !== 1'b0 || avs_readdata !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset_out irq=%b rd=%h exp 0", irq, avs_readdata);
      end
      for (int a = 0; a < 4; a++) begin
         bus_rd(a[1:0], d);
         checks++;
         if (d !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_reg%0d got=%h exp=0", a, d);
         end
      end
      repeat (5) @(negedge clk);
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL redeb_early got=%h exp=0", d);
      end
      bus_rd(2'd0, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL redeb_data got=%h exp=1", d);
      end
      bus_rd(2'd2, d);
      checks++;
      if (d !== 32'h1) begin
         failures++;
         $display("FAIL redeb_cap got=%h exp=1", d);
      end
      key_export = '1;
      repeat (12) @(negedge clk);
      bus_wr(2'd2, 32'hF);
   endtask

   task automatic test_random;
      int            hold [NK];
      logic [NK-1:0] pins;
      pins = '1;
      for (int i = 0; i < NK; i++) hold[i] = int'($urandom_range(1, 20));
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NK; i++) begin
            if (hold[i] == 0) begin
               pins[i] = ~pins[i];
               hold[i] = int'($urandom_range(1, 20));
            end else begin
               hold[i]--;
            end
         end
         key_export    = pins;
         avs_read      = 1'($urandom_range(0, 1));
         avs_write     = ($urandom_range(0, 2) == 0);
         avs_address   = 2'($urandom_range(0, 3));
         avs_writedata = $urandom;
         reset         = ($urandom_range(0, 799) == 0);
         @(negedge clk);
         checks++;
         if (avs_readdata !== m_rd) begin
            failures++;
            $display("FAIL rand_rd cyc=%0d got=%h exp=%h",
                     c, avs_readdata, m_rd);
         end
         checks++;
         if (irq !== |(m_cap & m_mask)) begin
            failures++;
            $display("FAIL rand_irq cyc=%0d got=%b exp=%b",
                     c, irq, |(m_cap & m_mask));
         end
      end
      avs_read  = 1'b0;
      avs_write = 1'b0;
      reset     = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      key_export    = '1;
      avs_address   = 2'd0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = 32'h0;
      test_reset();
      test_press();
      test_glitch();
      test_irq_edge_sel();
      test_set_wins();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_pio_debounce.md
KEY_PIO_DEBOUNCE -- requirements
Module: key_pio_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of key channels; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, clock cycles an input must hold a new level before it is accepted; legal range 2..2^24.
REQ-003 Parameter ACTIVE_LOW, default 1; when 1, a pin level of 0 is treated as pressed (logical 1).
REQ-004 clk_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 reset_reset  input  1  synchronous, active-high reset.
REQ-006 key_export  input  NUM_KEYS  raw, asynchronous key pins.
REQ-007 avs_address  input  2  word address of the register.
REQ-008 avs_read  input  1  read strobe.
REQ-009 avs_write  input  1  write strobe.
REQ-010 avs_writedata  input  32  write data.
REQ-011 avs_readdata  output  32  read data, valid one cycle after avs_read.
REQ-012 irq  output  1  level interrupt request, active-high.

Function
REQ-013 Each key_export bit SHALL pass through a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1, giving sync[i].
REQ-014 Each channel SHALL hold a stable bit and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 When sync[i]==stable[i], the counter SHALL clear to 0 on the next edge.
REQ-016 When sync[i]!=stable[i] and counter<DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 When sync[i]!=stable[i] and counter==DEBOUNCE_CYCLES-1, stable[i] SHALL take sync[i] and the counter SHALL clear, on the same edge.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles at sync[i] SHALL never change stable[i]; any return to the stable level restarts the count from 0.
REQ-019 Latency: a clean pin step SHALL change stable[i] exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new pin level.
REQ-020 Register map (word addresses): 0 DATA (RO, stable bits); 1 IRQ_MASK (RW); 2 EDGE_CAPTURE (write-1-to-clear); 3 EDGE_SEL (RW).
REQ-021 EDGE_SEL[i]=0 SHALL capture press only (stable 0->1); EDGE_SEL[i]=1 SHALL capture both 0->1 and 1->0.
REQ-022 A qualifying stable[i] transition SHALL set EDGE_CAPTURE[i] on the same edge that updates stable[i].
REQ-023 A write to address 2 SHALL clear each EDGE_CAPTURE bit whose avs_writedata bit is 1; bits with writedata 0 are unchanged.
REQ-024 A simultaneous clear and new qualifying edge on the same bit SHALL leave the bit set (set wins).
REQ-025 Writes to address 0 SHALL be ignored; writes to 1 and 3 SHALL load writedata[NUM_KEYS-1:0].
REQ-026 On avs_read, avs_readdata SHALL present the addressed register on the next edge, bits [31:NUM_KEYS] zero; avs_readdata SHALL hold its value when avs_read is low.
REQ-027 A read SHALL return register contents before any write presented in the same cycle.
REQ-028 irq SHALL equal OR over i of (EDGE_CAPTURE[i] & IRQ_MASK[i]), derived from registered state with no pin-to-irq combinational path.
REQ-029 Changing IRQ_MASK or EDGE_SEL SHALL neither set nor clear EDGE_CAPTURE bits.
REQ-030 Simultaneous avs_read and avs_write SHALL both be honoured per REQ-023..REQ-027.

Reset
REQ-031 On reset_reset=1 at a clock edge: synchronizers, stable bits, counters, IRQ_MASK, EDGE_CAPTURE, EDGE_SEL, avs_readdata SHALL become 0; irq SHALL be 0 from the next cycle.
REQ-032 Reset asserted mid-count SHALL discard the pending count; after release, a pressed key is re-debounced from 0 and generates a capture per REQ-022.
REQ-033 Reset SHALL take priority over all bus accesses in the same cycle.

Verification
REQ-034 NUM_KEYS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1: drive key_export=4'b1110 after reset -> DATA reads 4'b0001 exactly 10 edges after the first sampling edge, EDGE_CAPTURE=4'b0001.
REQ-035 Pulse key_export[1] low for 7 cycles -> DATA[1] and EDGE_CAPTURE[1] stay 0; a 8-cycle pulse sets both.
REQ-036 IRQ_MASK=4'b0001, press key 0 -> irq=1; write 0x1 to address 2 -> irq=0 next cycle, EDGE_CAPTURE=0.
REQ-037 EDGE_SEL=0, release key 0 -> no capture; EDGE_SEL=1, press then release -> capture set after each, cleared between by W1C.
REQ-038 Clear bit 2 in the same cycle stable[2] rises -> EDGE_CAPTURE[2] reads 1.
REQ-039 Assert reset 4 cycles into a key-0 debounce -> all registers read 0; after release, DATA[0]=1 arrives 10 edges later.
